// File: rtl/spi_master_mode0.sv
// rtl/spi_master_mode0.sv - SPI mode 0 master, MSB first, 8-bit frames; SPI_BURST_EN adds tx_last bursts
module spi_master_mode0 #(
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_data,
`ifdef SPI_BURST_EN
    input  logic       tx_last,
`endif
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       SCK,
    output logic       SSEL,
    output logic       MOSI,
    input  logic       MISO
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, GAP} state_t;

    state_t        state, state_d;
    logic [DW-1:0] div_cnt;
    logic [GW-1:0] gap_cnt;
    logic [2:0]    bit_cnt;
    logic [6:0]    tx_sr;
    logic [7:0]    rx_sr;
    logic          sck_q, ssel_q, mosi_q;
    logic          hold_wait;
    logic          end_frame;
    logic          accept;
    logic          phase_end;

`ifdef SPI_BURST_EN
    logic last_q;
    assign end_frame = last_q;
`else
    assign hold_wait = 1'b0;
    assign end_frame = 1'b1;
`endif

    assign ready     = (state == IDLE) || hold_wait;
    assign busy      = (state != IDLE);
    assign accept    = start && ready;
    assign phase_end = (div_cnt == DIV_LAST);
    assign SCK       = sck_q;
    assign SSEL      = ssel_q;
    assign MOSI      = mosi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:     if (accept) state_d = SETUP;
            SETUP:    if (phase_end) state_d = SHIFT_HI;
            SHIFT_HI: if (phase_end) state_d = SHIFT_LO;
            // bit_cnt wraps to 0 on the 8th rise; the trailing low phase then leads to HOLD
            SHIFT_LO: if (phase_end) state_d = (bit_cnt == 3'd0) ? HOLD : SHIFT_HI;
            HOLD: begin
                if (hold_wait) begin
                    if (accept) state_d = SETUP;
                end else if (phase_end && end_frame) begin
                    state_d = GAP;
                end
            end
            GAP:      if (gap_cnt == GAP_LAST) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q     <= 1'b0;
            ssel_q    <= 1'b1;
            mosi_q    <= 1'b0;
            done      <= 1'b0;
            rx_data   <= 8'h00;
            div_cnt   <= '0;
            gap_cnt   <= '0;
            bit_cnt   <= 3'd0;
            tx_sr     <= 7'd0;
            rx_sr     <= 8'h00;
`ifdef SPI_BURST_EN
            hold_wait <= 1'b0;
            last_q    <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            div_cnt <= (state_d != state || phase_end) ? '0 : div_cnt + DW'(1);
            gap_cnt <= (state == GAP) ? gap_cnt + GW'(1) : '0;
            if (accept) begin
                tx_sr     <= tx_data[6:0];
                mosi_q    <= tx_data[7];
                ssel_q    <= 1'b0;
                bit_cnt   <= 3'd0;
`ifdef SPI_BURST_EN
                last_q    <= tx_last;
                hold_wait <= 1'b0;
`endif
            end
            if (state != SHIFT_HI && state_d == SHIFT_HI) begin
                sck_q   <= 1'b1;
                rx_sr   <= {rx_sr[6:0], MISO};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (state == SHIFT_HI && state_d == SHIFT_LO) begin
                sck_q <= 1'b0;
                if (bit_cnt != 3'd0) begin
                    mosi_q <= tx_sr[6];
                    tx_sr  <= {tx_sr[5:0], 1'b0};
                end
            end
            if (state == HOLD && !hold_wait && phase_end) begin
                done    <= 1'b1;
                rx_data <= rx_sr;
                if (end_frame) begin
                    ssel_q <= 1'b1;
                    mosi_q <= 1'b0;
                end
`ifdef SPI_BURST_EN
                else begin
                    hold_wait <= 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_spi_master_mode0.sv
// tb/tb_spi_master_mode0.sv - scoreboard bench for spi_master_mode0 (loopback and slave model)
module tb_spi_master_mode0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] tx_data = 8'h00;
`ifdef SPI_BURST_EN
    logic       tx_last = 1'b1;
`endif
    logic       ready, busy, done;
    logic [7:0] rx_data;
    logic       sck, ssel, mosi, miso;

    int total = 0;
    int bad = 0;

    logic [7:0] exp_q[$];
    logic       loop_mode = 1'b1;
    logic [7:0] slave_byte = 8'h00;
    logic [7:0] slave_sr = 8'h00;
    logic       prev_sck = 1'b0;
    logic       prev_ssel = 1'b1;
    logic [7:0] mosi_word = 8'h00;
    int rise_cnt = 0;
    int ssel_low_cnt = 0;
    int ssel_rise_cnt = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    assign miso = loop_mode ? mosi : slave_sr[7];

    spi_master_mode0 #(.CLK_DIV(4), .GAP_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data),
`ifdef SPI_BURST_EN
        .tx_last(tx_last),
`endif
        .ready(ready), .busy(busy), .done(done), .rx_data(rx_data),
        .SCK(sck), .SSEL(ssel), .MOSI(mosi), .MISO(miso)
    );

    // Bus monitor and a mode-0 slave that shifts out on SCK falling edges
    always @(negedge clk) begin
        if (rst_n) begin
            if (sck && !prev_sck) begin
                rise_cnt  <= rise_cnt + 1;
                mosi_word <= {mosi_word[6:0], mosi};
            end
            if (!ssel) ssel_low_cnt <= ssel_low_cnt + 1;
            if (ssel && !prev_ssel) ssel_rise_cnt <= ssel_rise_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (!ssel && prev_ssel) slave_sr <= slave_byte;
            else if (!sck && prev_sck) slave_sr <= {slave_sr[6:0], 1'b0};
        end
        prev_sck  <= sck;
        prev_ssel <= ssel;
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (ready) ok = 1'b1;
        end
    endtask

    task automatic run_frame(input logic [7:0] b, input logic [7:0] exp_rx, input logic last,
                             output bit ok);
        bit got;
        got = 1'b0;
        start = 1'b1;
        tx_data = b;
`ifdef SPI_BURST_EN
        tx_last = last;
`else
        if (last) got = 1'b0;
`endif
        exp_q.push_back(exp_rx);
        @(negedge clk);
        start = 1'b0;
        tx_data = 8'($urandom);
        for (int i = 0; i < 400 && !got; i++) begin
            if (done) got = 1'b1;
            else @(negedge clk);
        end
        ok = got;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({sck, ssel, mosi, ready, busy, done} !== 6'b010100) begin
            bad++;
            $display("FAIL reset_pins got sck/ssel/mosi/ready/busy/done=%b want 010100",
                     {sck, ssel, mosi, ready, busy, done});
        end
        total++;
        if (rx_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_rx got %h want 00", rx_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_loopback(input logic [7:0] b);
        bit ok;
        int r0, s0, d0;
        logic [7:0] e;
        loop_mode = 1'b1;
        wait_ready(ok);
        r0 = rise_cnt; s0 = ssel_low_cnt; d0 = done_cnt;
        run_frame(b, b, 1'b1, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL loop_done_timeout got no done want done for %h", b);
            if (exp_q.size() > 0) void'(exp_q.pop_back());
            return;
        end
        e = exp_q.pop_front();
        total++;
        if (rx_data !== e) begin
            bad++;
            $display("FAIL loop_rx got %h want %h", rx_data, e);
        end
        @(negedge clk);
        total++;
        if (rise_cnt - r0 != 8 || ssel_low_cnt - s0 != 72 || mosi_word !== b) begin
            bad++;
            $display("FAIL loop_timing got rises=%0d ssel_low=%0d mosi=%h want 8 72 %h",
                     rise_cnt - r0, ssel_low_cnt - s0, mosi_word, b);
        end
        wait_ready(ok);
        total++;
        if (done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL loop_done_count got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_slave;
        bit ok;
        logic [7:0] e;
        loop_mode = 1'b0;
        slave_byte = 8'h3C;
        wait_ready(ok);
        run_frame(8'hFF, 8'h3C, 1'b1, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL slave_done_timeout got no done want done");
            if (exp_q.size() > 0) void'(exp_q.pop_back());
        end else begin
            e = exp_q.pop_front();
            total++;
            if (rx_data !== e) begin
                bad++;
                $display("FAIL slave_rx got %h want %h", rx_data, e);
            end
            @(negedge clk);
            total++;
            if (mosi_word !== 8'hFF) begin
                bad++;
                $display("FAIL slave_mosi got %h want ff", mosi_word);
            end
        end
        wait_ready(ok);
        loop_mode = 1'b1;
    endtask

    task automatic test_busy_start;
        bit ok;
        int r0, d0;
        logic [7:0] e;
        loop_mode = 1'b1;
        wait_ready(ok);
        r0 = rise_cnt; d0 = done_cnt;
        fork
            run_frame(8'hC3, 8'hC3, 1'b1, ok);
            begin
                repeat (20) @(negedge clk);
                start = 1'b1;
                tx_data = 8'h11;
                @(negedge clk);
                start = 1'b0;
            end
        join
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL busy_done_timeout got no done want done");
            if (exp_q.size() > 0) void'(exp_q.pop_back());
        end else begin
            e = exp_q.pop_front();
            total++;
            if (rx_data !== e) begin
                bad++;
                $display("FAIL busy_rx got %h want %h", rx_data, e);
            end
        end
        wait_ready(ok);
        repeat (150) @(negedge clk);
        total++;
        if (done_cnt - d0 != 1 || rise_cnt - r0 != 8) begin
            bad++;
            $display("FAIL busy_ignored got done=%0d rises=%0d want 1 8", done_cnt - d0, rise_cnt - r0);
        end
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        int r0, d0;
        loop_mode = 1'b1;
        wait_ready(ok);
        r0 = rise_cnt;
        start = 1'b1;
        tx_data = 8'hA5;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && (rise_cnt - r0) < 3; i++) @(negedge clk);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (ssel !== 1'b1 || sck !== 1'b0 || ready !== 1'b1 || rise_cnt - r0 != 3) begin
            bad++;
            $display("FAIL mid_reset got ssel=%b sck=%b ready=%b rises=%0d want 1 0 1 3",
                     ssel, sck, ready, rise_cnt - r0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        total++;
        if (done_cnt != d0 || ssel !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_nodone got done=%0d ssel=%b want 0 1", done_cnt - d0, ssel);
        end
        test_loopback(8'h5A);
    endtask

`ifdef SPI_BURST_EN
    task automatic test_burst;
        bit ok;
        int r0, d0, s0;
        logic [7:0] e;
        logic [7:0] bytes[3];
        bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03;
        loop_mode = 1'b1;
        wait_ready(ok);
        r0 = rise_cnt; d0 = done_cnt; s0 = ssel_rise_cnt;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) wait_ready(ok);
            run_frame(bytes[k], bytes[k], (k == 2), ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL burst_done_timeout got no done want done byte %0d", k);
                if (exp_q.size() > 0) void'(exp_q.pop_back());
            end else begin
                e = exp_q.pop_front();
                total++;
                if (rx_data !== e) begin
                    bad++;
                    $display("FAIL burst_rx got %h want %h", rx_data, e);
                end
            end
        end
        wait_ready(ok);
        total++;
        if (rise_cnt - r0 != 24 || done_cnt - d0 != 3 || ssel_rise_cnt - s0 != 1) begin
            bad++;
            $display("FAIL burst_frame got rises=%0d dones=%0d ssel_rises=%0d want 24 3 1",
                     rise_cnt - r0, done_cnt - d0, ssel_rise_cnt - s0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_loopback(8'hA5);
        test_loopback(8'h00);
        test_loopback(8'hFF);
        test_loopback(8'h81);
        test_slave();
        test_busy_start();
        test_reset_mid_frame();
`ifdef SPI_BURST_EN
        test_burst();
`endif
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_empty got %0d left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
